// File: rtl/bp_pkg.sv
// Shared defaults and reset constant for the branch predictor table.
// The counter reset value is "weakly not-taken": one below the taken threshold.
package bp_pkg;
    localparam int PC_W_DEF   = 32;
    localparam int IDX_W_DEF  = 4;
    localparam int CNT_W_DEF  = 2;
    localparam int STAT_W_DEF = 16;

    function automatic int cnt_rst_val(input int cnt_w);
        return (cnt_w <= 1) ? 0 : (1 << (cnt_w - 1)) - 1;
    endfunction

    localparam logic [CNT_W_DEF-1:0] CNT_RST_DEF = CNT_W_DEF'(cnt_rst_val(CNT_W_DEF));
endpackage

// File: rtl/bp_sat_ctr.sv
// One predictor-table entry: an up/down saturating counter with async reset.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_VAL = CNT_W'(cnt_rst_val(CNT_W))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (en) begin
            if (up && (count != '1))
                count <= count + 1'b1;
            else if (!up && (count != '0))
                count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: flop-based counter table, zero-cycle lookup,
// EX-stage resolve with flush generation and saturating statistics.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [PC_W-1:0]   lookup_pc_i,
    output logic              predict_o,
    input  logic              resolve_valid_i,
    input  logic [PC_W-1:0]   resolve_pc_i,
    input  logic              resolve_taken_i,
    input  logic              resolve_pred_i,
    output logic              IF_flush_o,
    output logic              ID_flush_o,
    output logic              mispredict_o,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);
    localparam int               ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(cnt_rst_val(CNT_W));

    logic [IDX_W-1:0]                w_lu_idx;
    logic [IDX_W-1:0]                w_rs_idx;
    logic [ENTRIES-1:0]              w_en;
    logic [ENTRIES-1:0][CNT_W-1:0]   w_table;
    logic                            w_mispredict;
    logic                            w_unused;
    logic                            r_mispredict;
    logic [STAT_W-1:0]               r_branch_cnt;
    logic [STAT_W-1:0]               r_mispred_cnt;

    // Word-aligned PCs: the two LSBs never select an entry.
    assign w_lu_idx = lookup_pc_i[IDX_W+1:2];
    assign w_rs_idx = resolve_pc_i[IDX_W+1:2];
    assign w_unused = ^{lookup_pc_i[PC_W-1:IDX_W+2], lookup_pc_i[1:0],
                        resolve_pc_i[PC_W-1:IDX_W+2], resolve_pc_i[1:0]};

    for (genvar g = 0; g < ENTRIES; g++) begin : g_tbl
        assign w_en[g] = resolve_valid_i && (w_rs_idx == IDX_W'(g));
        bp_sat_ctr #(
            .CNT_W   (CNT_W),
            .RST_VAL (RST_VAL)
        ) u_ctr (
            .clk   (clk_i),
            .rst_n (rst_n_i),
            .en    (w_en[g]),
            .up    (resolve_taken_i),
            .count (w_table[g])
        );
    end

    // Reads the registered table directly, so a same-index resolve is not bypassed.
    assign predict_o = w_table[w_lu_idx][CNT_W-1];

    assign w_mispredict = resolve_valid_i && (resolve_taken_i != resolve_pred_i);
    assign IF_flush_o   = w_mispredict;
    assign ID_flush_o   = w_mispredict;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mispredict  <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_mispredict <= w_mispredict;
            if (resolve_valid_i && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mispredict && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    assign mispredict_o  = r_mispredict;
    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;
endmodule
